// File: rtl/synth_pkg.sv
// Shared types and width constants for the wavetable voice scheduler.
package synth_pkg;

  // Sweep control states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Width of a select field able to index n entries (at least one bit).
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_NUM_WAVES = 4;
  localparam int DEF_NUM_BANDS = 22;

  // Select widths for the default table geometry, used by parents and benches.
  localparam int WAVE_W = sel_w(DEF_NUM_WAVES);
  localparam int BAND_W = sel_w(DEF_NUM_BANDS);

endpackage

// File: rtl/wavetable_voice_scheduler.sv
// Time-multiplexed wavetable voice mixer: on each sample tick it snapshots the
// voice settings, walks the voices through one shared external ROM and sums
// the enabled voices' samples into a full-precision mix.
module wavetable_voice_scheduler
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int LUT_BITS   = 10,
  parameter int DATA_W     = 24,
  parameter int NUM_WAVES  = DEF_NUM_WAVES,
  parameter int NUM_BANDS  = DEF_NUM_BANDS,
  localparam int WV_W  = sel_w(NUM_WAVES),
  localparam int BD_W  = sel_w(NUM_BANDS),
  localparam int IDX_W = $clog2(NUM_VOICES),
  localparam int ACC_W = DATA_W + IDX_W
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           sample_tick_i,
  input  logic [NUM_VOICES-1:0]          voice_en_i,
  input  logic [NUM_VOICES*LUT_BITS-1:0] voice_phase_i,
  input  logic [NUM_VOICES*WV_W-1:0]     voice_wave_i,
  input  logic [NUM_VOICES*BD_W-1:0]     voice_band_i,
  output logic [WV_W-1:0]                rom_wave_o,
  output logic [BD_W-1:0]                rom_band_o,
  output logic [LUT_BITS-1:0]            rom_phase_o,
  input  logic signed [DATA_W-1:0]       rom_data_i,
  output logic signed [ACC_W-1:0]        mix_o,
  output logic                           mix_valid_o,
  output logic                           busy_o,
  output logic                           overrun_o,
  input  logic                           clear_overrun_i
);

  // Sign-extend one ROM sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_W-1:0] d);
    return {{IDX_W{d[DATA_W-1]}}, d};
  endfunction

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d, sel_idx;
  logic [NUM_VOICES-1:0]   en_snap_q;
  logic [LUT_BITS-1:0]     phase_snap_q [NUM_VOICES];
  logic [WV_W-1:0]         wave_snap_q  [NUM_VOICES];
  logic [BD_W-1:0]         band_snap_q  [NUM_VOICES];
  logic signed [ACC_W-1:0] acc_q, acc_d, mix_q;
  logic                    ovr_q, ovr_d;
  logic                    vld_p1, en_p1;
  logic                    start, issue, last_issue;

  assign start      = (state_q == S_IDLE) && sample_tick_i;
  assign issue      = (state_q == S_ISSUE);
  assign last_issue = issue && (idx_q == IDX_W'(NUM_VOICES - 1));

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state: fixed-length sweep, ticks outside IDLE are not accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (sample_tick_i) state_d = S_ISSUE;
      S_ISSUE: if (last_issue)    state_d = S_DRAIN;
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: ROM address of the voice being issued (voice 0 otherwise).
  always_comb begin
    sel_idx = '0;
    if (issue) sel_idx = idx_q;
    rom_wave_o  = wave_snap_q[sel_idx];
    rom_band_o  = band_snap_q[sel_idx];
    rom_phase_o = phase_snap_q[sel_idx];
    busy_o      = (state_q != S_IDLE);
    mix_valid_o = (state_q == S_DONE);
  end

  // Datapath next-state: voice counter, accumulator and sticky overrun flag.
  always_comb begin
    idx_d = issue ? idx_q + 1'b1 : '0;
    acc_d = acc_q;
    if (start)                 acc_d = '0;
    else if (vld_p1 && en_p1)  acc_d = acc_q + sext(rom_data_i);
    ovr_d = ovr_q;
    if (sample_tick_i && (state_q != S_IDLE)) ovr_d = 1'b1;
    if (clear_overrun_i)                      ovr_d = 1'b0;
  end

  // Datapath registers: snapshot, issue pipeline, accumulator and mix result.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      idx_q     <= '0;
      acc_q     <= '0;
      mix_q     <= '0;
      ovr_q     <= 1'b0;
      vld_p1    <= 1'b0;
      en_p1     <= 1'b0;
      en_snap_q <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        phase_snap_q[v] <= '0;
        wave_snap_q[v]  <= '0;
        band_snap_q[v]  <= '0;
      end
    end else begin
      if (start) begin
        en_snap_q <= voice_en_i;
        for (int v = 0; v < NUM_VOICES; v++) begin
          phase_snap_q[v] <= voice_phase_i[v*LUT_BITS +: LUT_BITS];
          wave_snap_q[v]  <= voice_wave_i[v*WV_W +: WV_W];
          band_snap_q[v]  <= voice_band_i[v*BD_W +: BD_W];
        end
      end
      idx_q <= idx_d;
      // Stage p1: the ROM answers the address issued one cycle earlier.
      vld_p1 <= issue;
      en_p1  <= en_snap_q[idx_q];
      acc_q  <= acc_d;
      if (state_q == S_DRAIN) mix_q <= acc_d;
      ovr_q <= ovr_d;
    end
  end

  assign mix_o     = mix_q;
  assign overrun_o = ovr_q;

endmodule

// File: doc/wavetable_voice_scheduler.md
WAVETABLE_VOICE_SCHEDULER -- requirements
Module: wavetable_voice_scheduler

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 8, number of time-multiplexed voices (power of two, >=2).
REQ-002 SHALL have parameter LUT_BITS, default 10, phase/address bits per table.
REQ-003 SHALL have parameter DATA_W, default 24, signed sample width.
REQ-004 SHALL have parameters NUM_WAVES (default 4) and NUM_BANDS (default 22), with WAVE_W = $clog2(NUM_WAVES) and BAND_W = $clog2(NUM_BANDS).
REQ-005 SHALL have port clk_i, input, 1, the single clock.
REQ-006 SHALL have port rst_ni, input, 1, reset, synchronous, active-low.
REQ-007 SHALL have port sample_tick_i, input, 1, one-cycle strobe that starts one mixing sweep.
REQ-008 SHALL have port voice_en_i, input, NUM_VOICES, per-voice enable.
REQ-009 SHALL have port voice_phase_i, input, NUM_VOICES*LUT_BITS, per-voice table phase, with voice v at bits [v*LUT_BITS +: LUT_BITS].
REQ-010 SHALL have port voice_wave_i, input, NUM_VOICES*WAVE_W, per-voice waveform select.
REQ-011 SHALL have port voice_band_i, input, NUM_VOICES*BAND_W, per-voice band index.
REQ-012 SHALL have ports rom_wave_o (WAVE_W), rom_band_o (BAND_W) and rom_phase_o (LUT_BITS), all outputs, the address to the shared wavetable ROM.
REQ-013 SHALL have port rom_data_i, input, DATA_W signed, the ROM read data, valid exactly 1 cycle after its address.
REQ-014 SHALL have port mix_o, output, DATA_W+$clog2(NUM_VOICES) signed, the sum of enabled voices.
REQ-015 SHALL have port mix_valid_o, output, 1, one-cycle pulse when mix_o is updated.
REQ-016 SHALL have port busy_o, output, 1, high while a sweep is in progress.
REQ-017 SHALL have port overrun_o, output, 1, sticky flag set when a tick arrives while busy.
REQ-018 SHALL have port clear_overrun_i, input, 1, clears overrun_o.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-020 SHALL, in IDLE with sample_tick_i=1, snapshot all voice_* inputs into internal registers and go to ISSUE; voice_* changes after that edge SHALL not affect the current sweep.
REQ-021 SHALL, in ISSUE, present one voice's snapshot address per cycle in order 0..NUM_VOICES-1, taking exactly NUM_VOICES cycles, then go to DRAIN.
REQ-022 SHALL issue addresses for disabled voices too, giving fixed latency, but SHALL add 0 for them instead of rom_data_i.
REQ-023 SHALL clear the accumulator on sweep start and add sign-extended rom_data_i one cycle after each issue, carrying voice-valid/enable alongside in a 1-stage pipeline.
REQ-024 SHALL, in DRAIN (1 cycle), accumulate the last voice and go to DONE.
REQ-025 SHALL, in DONE (1 cycle), load mix_o from the accumulator, pulse mix_valid_o, and return to IDLE.
REQ-026 SHALL have latency: tick sampled at edge 0, mix_valid_o high during cycle NUM_VOICES+2 after it; busy_o high from cycle 1 through DONE inclusive.
REQ-027 SHALL size the accumulator at DATA_W+$clog2(NUM_VOICES) bits so it never overflows, with no saturation.
REQ-028 SHALL hold mix_o between sweeps.
REQ-029 SHALL ignore sample_tick_i while not in IDLE and set overrun_o; a tick in the same cycle as DONE SHALL also be ignored and set overrun_o.
REQ-030 SHALL have clear_overrun_i take priority over a simultaneous overrun set, so overrun_o ends 0.
REQ-031 SHALL drive the ROM address outputs to voice 0's snapshot in IDLE, DRAIN and DONE (don't-care for the ROM, but deterministic).

Reset
REQ-032 SHALL, on rst_ni=0 at a clock edge, go to IDLE and set mix_o=0, mix_valid_o=0, busy_o=0, overrun_o=0, voice index=0, accumulator=0 and all ROM address outputs=0.
REQ-033 SHALL, on reset during a sweep, abort it with no mix_valid_o pulse; the first tick after reset release SHALL start a clean sweep.

Structure
REQ-034 SHALL place the FSM state enum and the WAVE_W/BAND_W width constants in shared package synth_pkg.
REQ-035 SHALL be a single module; the ROM is external and instantiated by the parent, with no sub-modules.

Verification
REQ-036 SHALL test all-enabled: NUM_VOICES=8, voices with distinct wave/band/phase, ROM model returning data = phase (+1 to +8) -> mix_o=36, mix_valid_o at tick+10.
REQ-037 SHALL test enable mask: voice_en_i=8'b0000_0101, ROM returns -100 for voice 0, +300 for voice 2, 5000 for others -> mix_o=200.
REQ-038 SHALL test extremes: all voices enabled, ROM returns -2^23 -> mix_o=-2^26 with no wrap; returning 2^23-1 gives 8*(2^23-1).
REQ-039 SHALL test snapshot: change voice_phase_i on cycle tick+3 -> sum reflects the pre-tick phases, and the ROM address sequence matches the snapshot.
REQ-040 SHALL test overrun: a second tick at tick+4 -> ignored, a single mix_valid_o, overrun_o=1; clear_overrun_i plus a simultaneous extra tick while busy -> overrun_o=0.
REQ-041 SHALL test reset mid-sweep: rst_ni low at tick+5 -> no mix_valid_o, all outputs 0; a new tick then gives the correct sum at +10.
